// File: rtl/jtag_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_ctrl
// Brief    : 1149.1-style TAP controller clocked by internal_clk, advanced by tck_rise.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_tap_ctrl #(
    parameter int                      IR_WIDTH     = 4,
    parameter int                      DR_WIDTH     = 8,
    parameter logic [31:0]             IDCODE       = 32'h0000_0001,
    parameter logic [IR_WIDTH-1:0]     INSTR_IDCODE = 4'h1,
    parameter logic [IR_WIDTH-1:0]     INSTR_USER   = 4'h2
) (
    input  logic                internal_clk,
    input  logic                reset,
    input  logic                tck_rise,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_oe,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] ir_out,
    input  logic [DR_WIDTH-1:0] user_dr_in,
    output logic [DR_WIDTH-1:0] user_dr_out,
    output logic                user_update
);

    localparam logic [3:0] TLR    = 4'h0;
    localparam logic [3:0] RTI    = 4'h1;
    localparam logic [3:0] SEL_DR = 4'h2;
    localparam logic [3:0] CAP_DR = 4'h3;
    localparam logic [3:0] SH_DR  = 4'h4;
    localparam logic [3:0] EX1_DR = 4'h5;
    localparam logic [3:0] PA_DR  = 4'h6;
    localparam logic [3:0] EX2_DR = 4'h7;
    localparam logic [3:0] UPD_DR = 4'h8;
    localparam logic [3:0] SEL_IR = 4'h9;
    localparam logic [3:0] CAP_IR = 4'hA;
    localparam logic [3:0] SH_IR  = 4'hB;
    localparam logic [3:0] EX1_IR = 4'hC;
    localparam logic [3:0] PA_IR  = 4'hD;
    localparam logic [3:0] EX2_IR = 4'hE;
    localparam logic [3:0] UPD_IR = 4'hF;

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

    logic [3:0]          state;
    logic [3:0]          next_state;
    logic [IR_WIDTH-1:0] ir_shift;
    logic [31:0]         idcode_shift;
    logic [DR_WIDTH-1:0] user_shift;
    logic                bypass;

    assign tap_state = state;
    assign tdo_oe    = (state == SH_DR) || (state == SH_IR);

    always_comb begin
        next_state = state;
        case (state)
            TLR:     next_state = tms ? TLR    : RTI;
            RTI:     next_state = tms ? SEL_DR : RTI;
            SEL_DR:  next_state = tms ? SEL_IR : CAP_DR;
            CAP_DR:  next_state = tms ? EX1_DR : SH_DR;
            SH_DR:   next_state = tms ? EX1_DR : SH_DR;
            EX1_DR:  next_state = tms ? UPD_DR : PA_DR;
            PA_DR:   next_state = tms ? EX2_DR : PA_DR;
            EX2_DR:  next_state = tms ? UPD_DR : SH_DR;
            UPD_DR:  next_state = tms ? SEL_DR : RTI;
            SEL_IR:  next_state = tms ? TLR    : CAP_IR;
            CAP_IR:  next_state = tms ? EX1_IR : SH_IR;
            SH_IR:   next_state = tms ? EX1_IR : SH_IR;
            EX1_IR:  next_state = tms ? UPD_IR : PA_IR;
            PA_IR:   next_state = tms ? EX2_IR : PA_IR;
            EX2_IR:  next_state = tms ? UPD_IR : SH_IR;
            UPD_IR:  next_state = tms ? SEL_DR : RTI;
            default: next_state = TLR;
        endcase
    end

    always_ff @(posedge internal_clk) begin
        if (reset) begin
            state        <= TLR;
            ir_out       <= INSTR_IDCODE;
            ir_shift     <= '0;
            idcode_shift <= '0;
            user_shift   <= '0;
            bypass       <= 1'b0;
            tdo          <= 1'b0;
            user_dr_out  <= '0;
            user_update  <= 1'b0;
        end else begin
            user_update <= 1'b0;
            if (state == TLR) begin
                ir_out <= INSTR_IDCODE;
            end
            if (tck_rise) begin
                state <= next_state;
                // Actions belong to the state being left; tdo takes the pre-shift LSB.
                case (state)
                    CAP_IR: ir_shift <= IR_CAPTURE;
                    SH_IR: begin
                        tdo      <= ir_shift[0];
                        ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
                    end
                    CAP_DR: begin
                        if (ir_out == INSTR_IDCODE) begin
                            idcode_shift <= IDCODE;
                        end else if (ir_out == INSTR_USER) begin
                            user_shift <= user_dr_in;
                        end else begin
                            bypass <= 1'b0;
                        end
                    end
                    SH_DR: begin
                        if (ir_out == INSTR_IDCODE) begin
                            tdo          <= idcode_shift[0];
                            idcode_shift <= {tdi, idcode_shift[31:1]};
                        end else if (ir_out == INSTR_USER) begin
                            tdo        <= user_shift[0];
                            user_shift <= (DR_WIDTH > 1) ? {tdi, user_shift[DR_WIDTH-1:1]}
                                                          : {DR_WIDTH{tdi}};
                        end else begin
                            tdo    <= bypass;
                            bypass <= tdi;
                        end
                    end
                    default: ;
                endcase
                if (next_state == UPD_IR) begin
                    ir_out <= ir_shift;
                end
                if ((next_state == UPD_DR) && (ir_out == INSTR_USER)) begin
                    user_dr_out <= user_shift;
                    user_update <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_tap_ctrl
// Brief    : Scoreboard bench for jtag_tap_ctrl (state model + queued tdo bits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_ctrl;

    logic       internal_clk = 1'b0;
    logic       reset;
    logic       tck_rise;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_oe;
    logic [3:0] tap_state;
    logic [3:0] ir_out;
    logic [7:0] user_dr_in;
    logic [7:0] user_dr_out;
    logic       user_update;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         pulse_cnt = 0;
    logic [3:0] exp_state;
    logic       tdo_q[$];

    jtag_tap_ctrl dut (
        .internal_clk (internal_clk),
        .reset        (reset),
        .tck_rise     (tck_rise),
        .tms          (tms),
        .tdi          (tdi),
        .tdo          (tdo),
        .tdo_oe       (tdo_oe),
        .tap_state    (tap_state),
        .ir_out       (ir_out),
        .user_dr_in   (user_dr_in),
        .user_dr_out  (user_dr_out),
        .user_update  (user_update)
    );

    always #5 internal_clk = ~internal_clk;

    always @(posedge internal_clk) begin
        if (user_update === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] next_st(input logic [3:0] s, input logic m);
        case (s)
            4'h0: return m ? 4'h0 : 4'h1;
            4'h1: return m ? 4'h2 : 4'h1;
            4'h2: return m ? 4'h9 : 4'h3;
            4'h3: return m ? 4'h5 : 4'h4;
            4'h4: return m ? 4'h5 : 4'h4;
            4'h5: return m ? 4'h8 : 4'h6;
            4'h6: return m ? 4'h7 : 4'h6;
            4'h7: return m ? 4'h8 : 4'h4;
            4'h8: return m ? 4'h2 : 4'h1;
            4'h9: return m ? 4'h0 : 4'hA;
            4'hA: return m ? 4'hC : 4'hB;
            4'hB: return m ? 4'hC : 4'hB;
            4'hC: return m ? 4'hF : 4'hD;
            4'hD: return m ? 4'hE : 4'hD;
            4'hE: return m ? 4'hF : 4'hB;
            default: return m ? 4'h2 : 4'h1;
        endcase
    endfunction

    // One TCK rising strobe, then `gap` idle cycles during which nothing may move.
    task automatic tick(input logic m, input logic d, input int gap);
        @(negedge internal_clk);
        tck_rise = 1'b1;
        tms      = m;
        tdi      = d;
        @(negedge internal_clk);
        tck_rise  = 1'b0;
        exp_state = next_st(exp_state, m);
        check_val("state", {28'd0, tap_state}, {28'd0, exp_state});
        repeat (gap) begin
            @(negedge internal_clk);
            check_val("state_hold", {28'd0, tap_state}, {28'd0, exp_state});
        end
    endtask

    task automatic shift(input int n, input logic [31:0] din, input logic [31:0] exp_out, input int gmax);
        for (int i = 0; i < n; i++) begin
            tdo_q.push_back(exp_out[i]);
            tick(i == n - 1, din[i], int'($urandom_range(0, gmax)));
            check_val($sformatf("tdo[%0d]", i), {31'd0, tdo}, {31'd0, tdo_q.pop_front()});
        end
    endtask

    task automatic goto_shdr();
        tick(1'b1, 1'b0, 0);
        tick(1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 0);
        check_val("tdo_oe_dr", {31'd0, tdo_oe}, 32'd1);
    endtask

    task automatic goto_shir();
        tick(1'b1, 1'b0, 0);
        tick(1'b1, 1'b0, 0);
        tick(1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 0);
        check_val("tdo_oe_ir", {31'd0, tdo_oe}, 32'd1);
    endtask

    task automatic load_ir(input logic [3:0] val, input int gmax);
        goto_shir();
        shift(4, {28'd0, val}, 32'h1, gmax);
        tick(1'b1, 1'b0, 0);
        check_val("ir_out_upd", {28'd0, ir_out}, {28'd0, val});
        tick(1'b0, 1'b0, 0);
    endtask

    initial begin
        reset      = 1'b1;
        tck_rise   = 1'b0;
        tms        = 1'b1;
        tdi        = 1'b0;
        user_dr_in = 8'h00;
        exp_state  = 4'h0;
        repeat (3) @(negedge internal_clk);
        reset = 1'b0;
        @(negedge internal_clk);
        check_val("rst_state", {28'd0, tap_state}, 32'd0);
        check_val("rst_ir", {28'd0, ir_out}, 32'd1);
        check_val("rst_tdo", {31'd0, tdo}, 32'd0);
        check_val("rst_tdo_oe", {31'd0, tdo_oe}, 32'd0);
        check_val("rst_udr", {24'd0, user_dr_out}, 32'd0);
        check_val("rst_upd", {31'd0, user_update}, 32'd0);

        repeat (5) tick(1'b1, 1'b0, 0);
        check_val("tlr_ir", {28'd0, ir_out}, 32'd1);
        check_val("tlr_oe", {31'd0, tdo_oe}, 32'd0);
        check_val("tlr_upd", {31'd0, user_update}, 32'd0);
        tick(1'b0, 1'b0, 0);

        // IDCODE read with random strobe gaps.
        goto_shdr();
        shift(32, $urandom, 32'h0000_0001, 7);
        tick(1'b1, 1'b0, 0);
        check_val("idc_no_upd", {31'd0, user_update}, 32'd0);
        tick(1'b0, 1'b0, 0);

        load_ir(4'h2, 2);

        user_dr_in = 8'hA5;
        goto_shdr();
        shift(8, 32'h3C, 32'hA5, 3);
        tick(1'b1, 1'b0, 0);
        check_val("udr_out", {24'd0, user_dr_out}, 32'h3C);
        check_val("upd_pulse", {31'd0, user_update}, 32'd1);
        @(negedge internal_clk);
        check_val("upd_end", {31'd0, user_update}, 32'd0);
        check_val("pulse_cnt", pulse_cnt, 32'd1);
        tick(1'b0, 1'b0, 0);

        load_ir(4'hF, 0);
        goto_shdr();
        shift(4, 32'b1011, 32'b0110, 1);
        tick(1'b1, 1'b0, 0);
        tick(1'b0, 1'b0, 0);
        check_val("byp_no_upd", pulse_cnt, 32'd1);

        // SEL_IR with tms=1 exits to TLR; IR forced back to IDCODE there.
        tick(1'b1, 1'b0, 0);
        tick(1'b1, 1'b0, 0);
        tick(1'b1, 1'b0, 0);
        @(negedge internal_clk);
        check_val("tlr_force_ir", {28'd0, ir_out}, 32'd1);
        tick(1'b0, 1'b0, 0);

        goto_shir();
        tick(1'b0, 1'b1, 0);
        repeat (5) tick(1'b1, 1'b0, 1);
        check_val("five_ones", {28'd0, tap_state}, 32'd0);
        tick(1'b0, 1'b0, 0);

        // Reset in the middle of a user DR shift must abort without update.
        load_ir(4'h2, 0);
        user_dr_in = 8'h5A;
        goto_shdr();
        repeat (3) tick(1'b0, 1'b1, 0);
        @(negedge internal_clk);
        reset = 1'b1;
        @(negedge internal_clk);
        reset     = 1'b0;
        exp_state = 4'h0;
        check_val("mid_rst_state", {28'd0, tap_state}, 32'd0);
        check_val("mid_rst_ir", {28'd0, ir_out}, 32'd1);
        check_val("mid_rst_udr", {24'd0, user_dr_out}, 32'd0);
        check_val("mid_rst_oe", {31'd0, tdo_oe}, 32'd0);
        repeat (2) @(negedge internal_clk);
        check_val("mid_rst_pulse", pulse_cnt, 32'd1);

        // Back-to-back strobes after reset.
        tick(1'b0, 1'b0, 0);
        load_ir(4'h2, 0);
        goto_shdr();
        shift(8, 32'hC3, 32'h5A, 0);
        tick(1'b1, 1'b0, 0);
        check_val("udr_out2", {24'd0, user_dr_out}, 32'hC3);
        check_val("upd_pulse2", {31'd0, user_update}, 32'd1);
        tick(1'b0, 1'b0, 0);
        check_val("pulse_cnt2", pulse_cnt, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
